// File: rtl/lcd_status_display.sv
// HD44780 16x2 character-LCD driver: power-up init, then endless rewrite of a
// status line (recorder state) and a time line (elapsed seconds).
module lcd_status_display #(
    parameter int P_PWR_WAIT = 16000,
    parameter int P_EN_HIGH  = 1,
    parameter int P_CMD_WAIT = 40,
    parameter int P_CLR_WAIT = 2000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_state,
    input  logic [5:0] i_times,
    output logic [7:0] o_LCD_DATA,
    output logic       o_LCD_EN,
    output logic       o_LCD_RS,
    output logic       o_LCD_RW,
    output logic       o_LCD_ON,
    output logic       o_LCD_BLON,
    output logic       o_ready
);

    localparam int MAX_A = (P_PWR_WAIT > P_CLR_WAIT) ? P_PWR_WAIT : P_CLR_WAIT;
    localparam int MAX_B = (P_CMD_WAIT > P_EN_HIGH) ? P_CMD_WAIT : P_EN_HIGH;
    localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXP + 1);

    localparam logic [CW-1:0] PWR_W = CW'(P_PWR_WAIT);
    localparam logic [CW-1:0] EN_W  = CW'(P_EN_HIGH);
    localparam logic [CW-1:0] CMD_W = CW'(P_CMD_WAIT);
    localparam logic [CW-1:0] CLR_W = CW'(P_CLR_WAIT);

    typedef enum logic [2:0] {
        T_PWR_WAIT, T_INIT, T_ADDR1, T_LINE1, T_ADDR2, T_LINE2
    } top_t;

    typedef enum logic [1:0] {W_SETUP, W_PULSE, W_HOLD, W_WAIT} wr_t;

    top_t          top_reg, top_next;
    wr_t           wr_reg;
    logic [3:0]    idx_reg, idx_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] wait_len;
    logic [2:0]    snap_state_reg;
    logic [5:0]    snap_times_reg;
    logic [5:0]    tens_val, ones_val;
    logic [7:0]    data_reg, data_next;
    logic          rs_reg, rs_next;
    logic          en_reg, on_reg, ready_reg;
    logic          advance;

    function automatic logic [7:0] line1_char(input logic [2:0] st, input logic [3:0] idx);
        logic [127:0] s;
        case (st)
            3'd0:    s = "IDLE            ";
            3'd1:    s = "RECORD          ";
            3'd2:    s = "REC PAUSE       ";
            3'd3:    s = "PLAY            ";
            3'd4:    s = "PLAY PAUSE      ";
            default: s = "STATE ?         ";
        endcase
        return s[{4'd15 - idx, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] line2_char(input logic [5:0] tens, input logic [5:0] ones,
                                              input logic [3:0] idx);
        logic [127:0] s;
        s = {"TIME: ", 8'h30 + {2'b00, tens}, 8'h30 + {2'b00, ones}, " SEC    "};
        return s[{4'd15 - idx, 3'b000} +: 8];
    endfunction

    assign tens_val = snap_times_reg / 6'd10;
    assign ones_val = snap_times_reg % 6'd10;

    // Only the clear command needs the long settle time.
    assign wait_len = (!rs_reg && data_reg == 8'h01) ? CLR_W : CMD_W;

    assign advance = (top_reg == T_PWR_WAIT) ? (cnt_reg == PWR_W)
                                             : (wr_reg == W_WAIT && cnt_reg == wait_len);

    // Next byte position in the command/frame stream and its RS/DATA values.
    always_comb begin
        top_next  = top_reg;
        idx_next  = 4'(idx_reg + 4'd1);
        data_next = 8'h20;
        rs_next   = 1'b0;
        case (top_reg)
            T_PWR_WAIT: begin top_next = T_INIT;  idx_next = 4'd0; end
            T_INIT:     if (idx_reg == 4'd3) begin top_next = T_ADDR1; idx_next = 4'd0; end
            T_ADDR1:    begin top_next = T_LINE1; idx_next = 4'd0; end
            T_LINE1:    if (idx_reg == 4'd15) begin top_next = T_ADDR2; idx_next = 4'd0; end
            T_ADDR2:    begin top_next = T_LINE2; idx_next = 4'd0; end
            T_LINE2:    if (idx_reg == 4'd15) begin top_next = T_ADDR1; idx_next = 4'd0; end
            default:    begin top_next = T_PWR_WAIT; idx_next = 4'd0; end
        endcase
        case (top_next)
            T_INIT: begin
                case (idx_next[1:0])
                    2'd0:    data_next = 8'h38;
                    2'd1:    data_next = 8'h0C;
                    2'd2:    data_next = 8'h01;
                    default: data_next = 8'h06;
                endcase
            end
            T_ADDR1: data_next = 8'h80;
            T_LINE1: begin data_next = line1_char(snap_state_reg, idx_next); rs_next = 1'b1; end
            T_ADDR2: data_next = 8'hC0;
            T_LINE2: begin data_next = line2_char(tens_val, ones_val, idx_next); rs_next = 1'b1; end
            default: data_next = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            top_reg        <= T_PWR_WAIT;
            wr_reg         <= W_SETUP;
            idx_reg        <= 4'd0;
            cnt_reg        <= '0;
            snap_state_reg <= 3'd0;
            snap_times_reg <= 6'd0;
            data_reg       <= 8'h00;
            rs_reg         <= 1'b0;
            en_reg         <= 1'b0;
            on_reg         <= 1'b0;
            ready_reg      <= 1'b0;
        end else begin
            on_reg <= 1'b1;
            if (advance) begin
                top_reg  <= top_next;
                idx_reg  <= idx_next;
                data_reg <= data_next;
                rs_reg   <= rs_next;
                wr_reg   <= W_SETUP;
                if (top_reg == T_INIT && idx_reg == 4'd3)
                    ready_reg <= 1'b1;
                // The whole frame is rendered from inputs captured here.
                if (top_next == T_ADDR1) begin
                    snap_state_reg <= i_state;
                    snap_times_reg <= i_times;
                end
            end else if (top_reg == T_PWR_WAIT) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else begin
                case (wr_reg)
                    W_SETUP: begin
                        en_reg  <= 1'b1;
                        cnt_reg <= CW'(1);
                        wr_reg  <= W_PULSE;
                    end
                    W_PULSE: begin
                        if (cnt_reg == EN_W) begin
                            en_reg <= 1'b0;
                            wr_reg <= W_HOLD;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    W_HOLD: begin
                        cnt_reg <= CW'(1);
                        wr_reg  <= W_WAIT;
                    end
                    default: cnt_reg <= cnt_reg + 1'b1;
                endcase
            end
        end
    end

    assign o_LCD_DATA = data_reg;
    assign o_LCD_EN   = en_reg;
    assign o_LCD_RS   = rs_reg;
    assign o_LCD_RW   = 1'b0;
    assign o_LCD_ON   = on_reg;
    assign o_LCD_BLON = on_reg;
    assign o_ready    = ready_reg;

endmodule

// File: tb/tb_lcd_status_display.sv
// Randomized frame-content and strobe-timing check of lcd_status_display against
// a string-based model of the expected panel byte stream.
module tb_lcd_status_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] st;
    logic [5:0] tm;
    logic [7:0] lcd_data;
    logic       lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon, ready;

    int total = 0;
    int bad   = 0;

    localparam int NF = 10;
    logic [2:0] vs[NF];
    logic [5:0] vt[NF];

    always #5 clk = ~clk;

    lcd_status_display #(
        .P_PWR_WAIT(10), .P_EN_HIGH(2), .P_CMD_WAIT(4), .P_CLR_WAIT(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_state(st), .i_times(tm),
        .o_LCD_DATA(lcd_data), .o_LCD_EN(lcd_en), .o_LCD_RS(lcd_rs),
        .o_LCD_RW(lcd_rw), .o_LCD_ON(lcd_on), .o_LCD_BLON(lcd_blon), .o_ready(ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic string state_name(input logic [2:0] s);
        case (s)
            3'd0:    return "IDLE";
            3'd1:    return "RECORD";
            3'd2:    return "REC PAUSE";
            3'd3:    return "PLAY";
            3'd4:    return "PLAY PAUSE";
            default: return "STATE ?";
        endcase
    endfunction

    function automatic string pad16(input string s);
        string r = s;
        while (r.len() < 16) r = {r, " "};
        return r;
    endfunction

    // Byte k (0..33) of a frame: 0x80, line 1, 0xC0, line 2.
    function automatic logic [7:0] frame_byte(input int k, input logic [2:0] s, input logic [5:0] t);
        string l;
        if (k == 0) return 8'h80;
        if (k == 17) return 8'hC0;
        if (k <= 16) begin
            l = pad16(state_name(s));
            return l[k-1];
        end
        l = pad16($sformatf("TIME: %02d SEC", t));
        return l[k-18];
    endfunction

    // Wait for the next EN strobe; report RS/DATA at the rising edge, the
    // number of EN-low cycles before it and the EN-high length.
    task automatic get_write(input int gap0, output logic rs, output logic [7:0] d,
                             output int gap, output int hi);
        gap = gap0;
        @(negedge clk);
        while (!lcd_en) begin
            gap++;
            if (gap > 20000) begin
                $display("FAIL en_rise_timeout got=%0d exp=<20000", gap);
                $fatal(1);
            end
            @(negedge clk);
        end
        rs = lcd_rs;
        d  = lcd_data;
        hi = 1;
        @(negedge clk);
        while (lcd_en) begin
            hi++;
            if (hi > 1000) begin
                $display("FAIL en_fall_timeout got=%0d exp=<1000", hi);
                $fatal(1);
            end
            @(negedge clk);
        end
        chk("stable_data", lcd_data, d);
        chk("stable_rs", lcd_rs, rs);
        $display("wr rs=%0d data=%02h hi=%0d gap=%0d", rs, d, hi, gap);
    endtask

    task automatic powerup_init();
        logic [7:0] cmds[4];
        logic       rs;
        logic [7:0] d;
        int         gap, hi;
        cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("pwr_on", lcd_on, 1);
        chk("pwr_blon", lcd_blon, 1);
        chk("pwr_en", lcd_en, 0);
        chk("pwr_ready", ready, 0);
        for (int i = 0; i < 4; i++) begin
            get_write(1, rs, d, gap, hi);
            chk("init_data", d, cmds[i]);
            chk("init_rs", rs, 0);
            chk("init_hi", hi, 2);
            chk("init_gap", gap, (i == 0) ? 11 : (i == 3) ? 10 : 6);
            chk("init_ready", ready, 0);
        end
    endtask

    // One full frame expected from (s,t); optionally change inputs mid-LINE1.
    task automatic do_frame(input logic [2:0] s, input logic [5:0] t, input logic chg,
                            input logic [2:0] ns, input logic [5:0] nt);
        logic       rs;
        logic [7:0] d;
        int         gap, hi, at;
        at = $urandom_range(1, 16);
        for (int k = 0; k < 34; k++) begin
            get_write(1, rs, d, gap, hi);
            chk("frame_data", d, frame_byte(k, s, t));
            chk("frame_rs", rs, (k == 0 || k == 17) ? 0 : 1);
            chk("frame_hi", hi, 2);
            chk("frame_gap", gap, 6);
            if (k == 0) chk("frame_ready", ready, 1);
            if (chg && k == at) begin
                st = ns;
                tm = nt;
            end
        end
    endtask

    initial begin
        logic       rs;
        logic [7:0] d;
        int         gap, hi, n;

        vs[0] = 3'd3; vt[0] = 6'd42;
        vs[1] = 3'd3; vt[1] = 6'd43;
        vs[2] = 3'd7; vt[2] = 6'd0;
        vs[3] = 3'($urandom_range(0, 7)); vt[3] = 6'd63;
        vs[4] = 3'd2; vt[4] = 6'($urandom_range(0, 63));
        for (int i = 5; i < NF; i++) begin
            vs[i] = 3'($urandom_range(0, 7));
            vt[i] = 6'($urandom_range(0, 63));
        end

        st = vs[0];
        tm = vt[0];
        repeat (3) @(negedge clk);
        chk("rst_en", lcd_en, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_on", lcd_on, 0);
        chk("rst_blon", lcd_blon, 0);
        chk("rst_ready", ready, 0);
        chk("rst_rw", lcd_rw, 0);

        powerup_init();
        for (int f = 0; f < NF; f++)
            do_frame(vs[f], vt[f], (f < NF - 1), vs[(f < NF - 1) ? f + 1 : f], vt[(f < NF - 1) ? f + 1 : f]);

        // Partial frame, then reset while EN is high during LINE2.
        for (int k = 0; k < 21; k++) begin
            get_write(1, rs, d, gap, hi);
            chk("pre_rst_data", d, frame_byte(k, vs[NF-1], vt[NF-1]));
        end
        n = 0;
        @(negedge clk);
        while (!lcd_en && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("mid_en_high", lcd_en, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_en", lcd_en, 0);
        chk("arst_rs", lcd_rs, 0);
        chk("arst_data", lcd_data, 0);
        chk("arst_on", lcd_on, 0);
        chk("arst_blon", lcd_blon, 0);
        chk("arst_ready", ready, 0);
        repeat (2) @(negedge clk);

        st = 3'd1;
        tm = 6'd9;
        powerup_init();
        do_frame(3'd1, 6'd9, 1'b0, 3'd0, 6'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
